mem_ctrl: RTL and testbench

- Serialises instruction fetches (IF stage) and data loads/stores (MEM stage) onto a single byte-wide RAM port.
- Generates the stall requests stallreq_if and stallreq_mem consumed by the pipeline stall controller. It is the requesting end of the stall interface.
- The MEM stage has priority over IF.
- Multi-byte accesses are little-endian, one byte per cycle.

---
 rtl/mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Single byte-wide RAM port arbiter: serialises IF fetches and MEM loads/stores,
// MEM first, little-endian one byte per cycle, and raises the pipeline stall requests.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic [2:0]        len_n, len_nx;
    logic [31:0]       wdata, wdata_nx;
    logic              owner_mem, owner_nx;
    logic [31:0]       rbuf, rbuf_nx;
    logic [31:0]       if_data_nx, mem_rdata_nx;
    logic [ADDR_W-1:0] ram_a_nx;
    logic              ram_wr_nx;
    logic [7:0]        ram_dout_nx;

    logic [1:0]        cap_idx;
    logic [1:0]        wr_idx;
    logic [ADDR_W-1:0] next_a;
    logic              more_bytes;

    function automatic logic [2:0] len_decode(input logic [1:0] l);
        case (l)
            2'b00:   len_decode = 3'd1;
            2'b01:   len_decode = 3'd2;
            default: len_decode = 3'd4;
        endcase
    endfunction

    // cnt counts cycles since acceptance; reads see byte cnt-1 on ram_din one cycle late
    assign cap_idx    = cnt[1:0] - 2'd1;
    assign wr_idx     = cnt[1:0] + 2'd1;
    assign next_a     = base + ADDR_W'(cnt + 3'd1);
    assign more_bytes = (cnt + 3'd1) < len_n;

    assign if_done      = (state == DONE) && !owner_mem;
    assign mem_done     = (state == DONE) && owner_mem;
    assign stallreq_if  = if_req & ~if_done;
    assign stallreq_mem = mem_req & ~mem_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            len_n     <= '0;
            wdata     <= '0;
            owner_mem <= 1'b0;
            rbuf      <= '0;
            if_data   <= '0;
            mem_rdata <= '0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            base      <= base_nx;
            len_n     <= len_nx;
            wdata     <= wdata_nx;
            owner_mem <= owner_nx;
            rbuf      <= rbuf_nx;
            if_data   <= if_data_nx;
            mem_rdata <= mem_rdata_nx;
            ram_a     <= ram_a_nx;
            ram_wr    <= ram_wr_nx;
            ram_dout  <= ram_dout_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        base_nx      = base;
        len_nx       = len_n;
        wdata_nx     = wdata;
        owner_nx     = owner_mem;
        rbuf_nx      = rbuf;
        if_data_nx   = if_data;
        mem_rdata_nx = mem_rdata;
        ram_a_nx     = '0;
        ram_wr_nx    = 1'b0;
        ram_dout_nx  = '0;

        case (state)
            IDLE: begin
                if (mem_req) begin
                    state_nx    = mem_we ? MEM_WR : MEM_RD;
                    base_nx     = mem_addr;
                    len_nx      = len_decode(mem_len);
                    wdata_nx    = mem_wdata;
                    owner_nx    = 1'b1;
                    cnt_nx      = '0;
                    rbuf_nx     = '0;
                    ram_a_nx    = mem_addr;
                    ram_wr_nx   = mem_we;
                    ram_dout_nx = mem_we ? mem_wdata[7:0] : 8'h00;
                end else if (if_req) begin
                    state_nx = IF_RD;
                    base_nx  = if_addr;
                    len_nx   = 3'd4;
                    owner_nx = 1'b0;
                    cnt_nx   = '0;
                    rbuf_nx  = '0;
                    ram_a_nx = if_addr;
                end
            end

            // A dropped if_req flushes the fetch; MEM reads always run to completion
            IF_RD, MEM_RD: begin
                if (state == IF_RD && !if_req) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 3'd1;
                    if (cnt != 3'd0) begin
                        for (int i = 0; i < 4; i++) begin
                            if (cap_idx == 2'(i)) rbuf_nx[8*i +: 8] = ram_din;
                        end
                    end
                    if (more_bytes) ram_a_nx = next_a;
                    if (cnt == len_n) begin
                        state_nx = DONE;
                        if (owner_mem) mem_rdata_nx = rbuf_nx;
                        else           if_data_nx   = rbuf_nx;
                    end
                end
            end

            MEM_WR: begin
                if (more_bytes) begin
                    cnt_nx      = cnt + 3'd1;
                    ram_a_nx    = next_a;
                    ram_wr_nx   = 1'b1;
                    ram_dout_nx = wdata[{wr_idx, 3'b000} +: 8];
                end else begin
                    state_nx = DONE;
                end
            end

            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: cycle-by-cycle vector table plus hand-written
// sequences for loads, IF flush, mid-access reset and address wrap.
module tb_mem_ctrl;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic              stallreq_if;
    logic              stallreq_mem;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_done      (if_done),
        .if_data      (if_data),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_len      (mem_len),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .ram_a        (ram_a),
        .ram_wr       (ram_wr)
    );

    // RAM model: one-cycle read latency, contents reloaded whenever rst is high
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (rst) begin
            ram[16'h0100] <= 8'h13;
            ram[16'h0101] <= 8'h05;
            ram[16'h0102] <= 8'h10;
            ram[16'h0103] <= 8'h00;
            ram[16'h0003] <= 8'h80;
            ram[16'h0010] <= 8'h34;
            ram[16'h0011] <= 8'h12;
            ram[16'hFFFE] <= 8'hAA;
            ram[16'hFFFF] <= 8'hBB;
            ram[16'h0000] <= 8'hCC;
            ram[16'h0001] <= 8'hDD;
        end else if (ram_wr) begin
            ram[ram_a[15:0]] <= ram_dout;
        end
        ram_din <= ram[ram_a[15:0]];
    end

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [1:0]  mem_len;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] exp_ram_a;
        logic        exp_ram_wr;
        logic [7:0]  exp_ram_dout;
        logic        exp_if_done;
        logic        exp_mem_done;
        logic        exp_stall_if;
        logic        exp_stall_mem;
        logic [31:0] exp_if_data;
        logic [31:0] exp_mem_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(
        input logic ifr, input logic [31:0] ifa,
        input logic mr, input logic mwe, input logic [1:0] ml,
        input logic [31:0] ma, input logic [31:0] mwd,
        input logic [31:0] ea, input logic ewr, input logic [7:0] ed,
        input logic eifd, input logic emd, input logic esi, input logic esm,
        input logic [31:0] eid, input logic [31:0] emr);
        vec_t t;
        t = '{ifr, ifa, mr, mwe, ml, ma, mwd, ea, ewr, ed, eifd, emd, esi, esm, eid, emr};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        mem_req   = v.mem_req;
        mem_we    = v.mem_we;
        mem_len   = v.mem_len;
        mem_addr  = v.mem_addr;
        mem_wdata = v.mem_wdata;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check($sformatf("vec%0d ram_a", idx), ram_a, v.exp_ram_a);
        check($sformatf("vec%0d ram_wr", idx), 32'(ram_wr), 32'(v.exp_ram_wr));
        if (v.exp_ram_wr)
            check($sformatf("vec%0d ram_dout", idx), 32'(ram_dout), 32'(v.exp_ram_dout));
        check($sformatf("vec%0d if_done", idx), 32'(if_done), 32'(v.exp_if_done));
        check($sformatf("vec%0d mem_done", idx), 32'(mem_done), 32'(v.exp_mem_done));
        check($sformatf("vec%0d stallreq_if", idx), 32'(stallreq_if), 32'(v.exp_stall_if));
        check($sformatf("vec%0d stallreq_mem", idx), 32'(stallreq_mem), 32'(v.exp_stall_mem));
        check($sformatf("vec%0d if_data", idx), if_data, v.exp_if_data);
        check($sformatf("vec%0d mem_rdata", idx), mem_rdata, v.exp_mem_rdata);
    endtask

    // One MEM access with mem_req held until done; checks completion cycle and load data
    task automatic runMem(input string name, input logic we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_cyc, input logic [31:0] exp_rd);
        int cyc;
        cyc = -1;
        @(negedge clk);
        if_req    = 1'b0;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_len   = len;
        mem_addr  = addr;
        mem_wdata = wd;
        #1;
        check({name, " stallreq_mem at start"}, 32'(stallreq_mem), 32'd1);
        for (int c = 0; c <= 20; c++) begin
            if (mem_done) begin
                cyc = c;
                break;
            end
            @(negedge clk);
            #1;
        end
        check({name, " done cycle"}, 32'(cyc), 32'(exp_cyc));
        if (cyc >= 0) begin
            check({name, " stallreq_mem in done"}, 32'(stallreq_mem), 32'd0);
            if (!we) check({name, " mem_rdata"}, mem_rdata, exp_rd);
        end
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        check({name, " done is one pulse"}, 32'(mem_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_cnt;
        int wr_cnt;
        logic [31:0] wrap_a [4];

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = '0; mem_wdata = '0;

        // IF fetch at 0x100, then simultaneous store/IF with MEM priority
        vecs.push_back(mkv(1, 32'h100, 0, 0, 2'b00, 0, 0,            32'h0,    0, 8'h00, 0, 0, 1, 0, 32'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h100, 0, 0, 2'b00, 0, 0,            32'h100,  0, 8'h00, 0, 0, 1, 0, 32'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h100, 0, 0, 2'b00, 0, 0,            32'h101,  0, 8'h00, 0, 0, 1, 0, 32'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h100, 0, 0, 2'b00, 0, 0,            32'h102,  0, 8'h00, 0, 0, 1, 0, 32'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h100, 0, 0, 2'b00, 0, 0,            32'h103,  0, 8'h00, 0, 0, 1, 0, 32'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h100, 0, 0, 2'b00, 0, 0,            32'h0,    0, 8'h00, 0, 0, 1, 0, 32'h0, 32'h0));
        vecs.push_back(mkv(1, 32'h100, 0, 0, 2'b00, 0, 0,            32'h0,    0, 8'h00, 1, 0, 0, 0, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 1, 1, 2'b10, 32'h2000, 32'hDEADBEEF, 32'h0,    0, 8'h00, 0, 0, 1, 1, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 1, 1, 2'b10, 32'h2000, 32'hDEADBEEF, 32'h2000, 1, 8'hEF, 0, 0, 1, 1, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 1, 1, 2'b10, 32'h2000, 32'hDEADBEEF, 32'h2001, 1, 8'hBE, 0, 0, 1, 1, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 1, 1, 2'b10, 32'h2000, 32'hDEADBEEF, 32'h2002, 1, 8'hAD, 0, 0, 1, 1, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 1, 1, 2'b10, 32'h2000, 32'hDEADBEEF, 32'h2003, 1, 8'hDE, 0, 0, 1, 1, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 1, 1, 2'b10, 32'h2000, 32'hDEADBEEF, 32'h0,    0, 8'h00, 0, 1, 1, 0, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 0, 0, 2'b00, 0, 0,            32'h0,    0, 8'h00, 0, 0, 1, 0, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 0, 0, 2'b00, 0, 0,            32'h2000, 0, 8'h00, 0, 0, 1, 0, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 0, 0, 2'b00, 0, 0,            32'h2001, 0, 8'h00, 0, 0, 1, 0, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 0, 0, 2'b00, 0, 0,            32'h2002, 0, 8'h00, 0, 0, 1, 0, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 0, 0, 2'b00, 0, 0,            32'h2003, 0, 8'h00, 0, 0, 1, 0, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 0, 0, 2'b00, 0, 0,            32'h0,    0, 8'h00, 0, 0, 1, 0, 32'h00100513, 32'h0));
        vecs.push_back(mkv(1, 32'h2000, 0, 0, 2'b00, 0, 0,            32'h0,    0, 8'h00, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mkv(0, 32'h0,    0, 0, 2'b00, 0, 0,            32'h0,    0, 8'h00, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0));

        repeat (3) @(negedge clk);
        #1;
        check("reset ram_a", ram_a, 32'h0);
        check("reset ram_wr", 32'(ram_wr), 32'd0);
        check("reset ram_dout", 32'(ram_dout), 32'd0);
        check("reset if_done", 32'(if_done), 32'd0);
        check("reset mem_done", 32'(mem_done), 32'd0);
        check("reset if_data", if_data, 32'h0);
        check("reset mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end

        // Half load first so the later byte load shows zero extension
        runMem("half load", 1'b0, 2'b01, 32'h10, 32'h0, 4, 32'h00001234);
        runMem("byte load", 1'b0, 2'b00, 32'h3,  32'h0, 3, 32'h00000080);

        // IF flush: if_req dropped in cycle 2
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        done_cnt = 0; wr_cnt = 0;
        @(negedge clk); #1;
        check("abort ram_a c1", ram_a, 32'h100);
        wr_cnt += int'(ram_wr);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        check("abort ram_a c2", ram_a, 32'h101);
        wr_cnt += int'(ram_wr);
        @(negedge clk); #1;
        check("abort ram_a idle", ram_a, 32'h0);
        for (int c = 0; c < 8; c++) begin
            done_cnt += int'(if_done);
            wr_cnt   += int'(ram_wr);
            @(negedge clk); #1;
        end
        check("abort if_done count", 32'(done_cnt), 32'd0);
        check("abort ram_wr count", 32'(wr_cnt), 32'd0);
        check("abort if_data held", if_data, 32'hDEADBEEF);

        // Reset asserted during cycle 2 of a word store
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h40; mem_wdata = 32'h11223344;
        @(negedge clk); #1;
        check("rst-store ram_a c1", ram_a, 32'h40);
        check("rst-store ram_wr c1", 32'(ram_wr), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst-store ram_dout c2", 32'(ram_dout), 32'h33);
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0;
        #1;
        check("rst-store ram_wr after", 32'(ram_wr), 32'd0);
        check("rst-store ram_a after", ram_a, 32'h0);
        check("rst-store ram_dout after", 32'(ram_dout), 32'd0);
        check("rst-store if_data after", if_data, 32'h0);
        check("rst-store mem_rdata after", mem_rdata, 32'h0);
        check("rst-store mem_done after", 32'(mem_done), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            done_cnt += int'(mem_done);
            @(negedge clk); #1;
        end
        check("rst-store mem_done count", 32'(done_cnt), 32'd0);
        runMem("store after reset", 1'b1, 2'b10, 32'h40, 32'h11223344, 5, 32'h0);
        runMem("load after reset",  1'b0, 2'b10, 32'h40, 32'h0,        6, 32'h11223344);

        // Word fetch wrapping past the top of the address space
        wrap_a[0] = 32'hFFFFFFFE;
        wrap_a[1] = 32'hFFFFFFFF;
        wrap_a[2] = 32'h00000000;
        wrap_a[3] = 32'h00000001;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'hFFFFFFFE;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            check($sformatf("wrap ram_a c%0d", c), ram_a, wrap_a[c-1]);
        end
        @(negedge clk);
        @(negedge clk); #1;
        check("wrap if_done", 32'(if_done), 32'd1);
        check("wrap if_data", if_data, 32'hDDCCBBAA);
        if_req = 1'b0;

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
